// File: rtl/bcd_countdown_timer.sv
// Packed-BCD down counter with parallel load, pause, reload-on-restart and terminal-count detection.
// Latency: count, state and flags all update one clock edge after the qualifying input. No backpressure.
module bcd_countdown_timer #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic                  expired
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           expired_q, expired_d;
    logic           running_q, running_d;
    logic           done_q, done_d;

    logic [W-1:0]   sanitized;
    logic [W-1:0]   count_dec;
    logic           borrow;

    // Clamp each illegal digit to 9; borrow ripples through every digit in one cycle.
    always_comb begin
        sanitized = '0;
        count_dec = '0;
        borrow    = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            sanitized[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end else begin
                count_dec[4*i +: 4] = count_q[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        if (load) begin
            count_d  = sanitized;
            reload_d = sanitized;
            state_d  = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (count_q != '0) begin
                            state_d = S_RUN;
                        end else begin
                            state_d   = S_DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (tick && count_q != '0) begin
                        count_d = count_dec;
                        if (count_q == W'(1)) begin
                            state_d   = S_DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        if (reload_q != '0) begin
                            count_d = reload_q;
                            state_d = S_RUN;
                        end else begin
                            expired_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with DIGITS=2 and hand-computed expectations.
module tb_bcd_countdown_timer;

    logic       clock;
    logic       reset;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       pause;
    logic       tick;
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       expired;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_countdown_timer #(.DIGITS(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .tick       (tick),
        .count      (count),
        .running    (running),
        .done       (done),
        .expired    (expired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_value = v; cyc(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        tick = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL rst_count got %h want 00", count); end
        n_checks++; if ({running, done, expired} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {running, done, expired}); end
        reset = 1'b1;
        cyc();
        do_load(8'h25);
        do_start();
        do_ticks(3);
        n_checks++; if (count !== 8'h22) begin n_fail++; $display("FAIL mid_count got %h want 22", count); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL mid_running got %b want 1", running); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL async_count got %h want 00", count); end
        n_checks++; if ({running, done} !== 2'b00) begin n_fail++; $display("FAIL async_flags got %b want 00", {running, done}); end
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_borrow();
        do_load(8'h10);
        do_start();
        do_ticks(1);
        n_checks++; if (count !== 8'h09) begin n_fail++; $display("FAIL borrow1 got %h want 09", count); end
        do_ticks(1);
        n_checks++; if (count !== 8'h08) begin n_fail++; $display("FAIL borrow2 got %h want 08", count); end
        do_load(8'h20);
        do_start();
        do_ticks(1);
        n_checks++; if (count !== 8'h19) begin n_fail++; $display("FAIL borrow3 got %h want 19", count); end
        do_load(8'h00);
        do_start();
        n_checks++; if ({done, expired} !== 2'b11) begin n_fail++; $display("FAIL zero_start got %b want 11", {done, expired}); end
        cyc();
        n_checks++; if ({done, expired} !== 2'b10) begin n_fail++; $display("FAIL zero_pulse got %b want 10", {done, expired}); end
        do_start();
        n_checks++; if ({done, running, expired} !== 3'b101) begin n_fail++; $display("FAIL zero_reexpire got %b want 101", {done, running, expired}); end
        cyc();
        n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL zero_reexpire_end got %b want 0", expired); end
    endtask

    task automatic test_terminal();
        do_load(8'h02);
        do_start();
        do_ticks(1);
        n_checks++; if (count !== 8'h01) begin n_fail++; $display("FAIL term1 got %h want 01", count); end
        tick = 1'b1;
        cyc();
        n_checks++; if ({count, done, running, expired} !== {8'h00, 3'b101}) begin n_fail++; $display("FAIL term0 got %h/%b want 00/101", count, {done, running, expired}); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++; if ({count, done, expired} !== {8'h00, 2'b10}) begin n_fail++; $display("FAIL term_hold%0d got %h/%b want 00/10", i, count, {done, expired}); end
        end
        tick = 1'b0;
    endtask

    task automatic test_sanitize_priority();
        do_load(8'hAF);
        n_checks++; if (count !== 8'h99) begin n_fail++; $display("FAIL sanitize got %h want 99", count); end
        do_load(8'h7C);
        n_checks++; if (count !== 8'h79) begin n_fail++; $display("FAIL sanitize_lo got %h want 79", count); end
        start = 1'b1; tick = 1'b1;
        do_load(8'h30);
        start = 1'b0; tick = 1'b0;
        n_checks++; if ({count, running, done} !== {8'h30, 2'b00}) begin n_fail++; $display("FAIL prio got %h/%b want 30/00", count, {running, done}); end
    endtask

    task automatic test_pause();
        do_load(8'h05);
        do_start();
        do_ticks(1);
        n_checks++; if (count !== 8'h04) begin n_fail++; $display("FAIL pause_pre got %h want 04", count); end
        pause = 1'b1; tick = 1'b1; start = 1'b1;
        cyc();
        pause = 1'b0; tick = 1'b0; start = 1'b0;
        n_checks++; if ({count, running} !== {8'h04, 1'b0}) begin n_fail++; $display("FAIL pause_hold got %h/%b want 04/0", count, running); end
        do_ticks(3);
        n_checks++; if (count !== 8'h04) begin n_fail++; $display("FAIL pause_ticks got %h want 04", count); end
        start = 1'b1; tick = 1'b1;
        cyc();
        start = 1'b0; tick = 1'b0;
        n_checks++; if ({count, running} !== {8'h04, 1'b1}) begin n_fail++; $display("FAIL resume got %h/%b want 04/1", count, running); end
        do_ticks(1);
        n_checks++; if (count !== 8'h03) begin n_fail++; $display("FAIL resume_tick got %h want 03", count); end
    endtask

    task automatic test_restart();
        do_load(8'h03);
        do_start();
        do_ticks(3);
        n_checks++; if ({count, done, expired} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL rs_done got %h/%b want 00/11", count, {done, expired}); end
        cyc();
        do_start();
        n_checks++; if ({count, running, done, expired} !== {8'h03, 3'b100}) begin n_fail++; $display("FAIL rs_restart got %h/%b want 03/100", count, {running, done, expired}); end
        do_ticks(2);
        n_checks++; if ({count, expired} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL rs_mid got %h/%b want 01/0", count, expired); end
        do_ticks(1);
        n_checks++; if ({count, done, expired} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL rs_end got %h/%b want 00/11", count, {done, expired}); end
        cyc();
        n_checks++; if ({done, expired} !== 2'b10) begin n_fail++; $display("FAIL rs_pulse got %b want 10", {done, expired}); end
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_value = 8'h00;
        start = 1'b0; pause = 1'b0; tick = 1'b0;
        #3;
        test_reset();
        test_borrow();
        test_terminal();
        test_sanitize_priority();
        test_pause();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Multi-digit packed-BCD down counter with parallel load, reload-on-restart, pause and terminal-count detection. It is the count-down counterpart of the team's BCD up counters. It sits behind the display/timer datapath, decrementing once per qualified tick. It signals expiry to control logic and holds at zero.

Parameters:
DIGITS, 2, number of BCD digits (count width = 4*DIGITS); legal range 1-8.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (low = reset asserted)
load  input  1  synchronous parallel load strobe
load_value  input  4*DIGITS  packed BCD preset value, digit 0 in bits [3:0]
start  input  1  start / resume / restart request
pause  input  1  pause request
tick  input  1  decrement qualifier, one step per clock with tick=1
count  output  4*DIGITS  current packed BCD value
running  output  1  high while in RUN
done  output  1  high while in DONE
expired  output  1  one-cycle pulse on the first cycle in DONE

Behaviour:
- Reset
  - reset=0 takes effect immediately, with no clock edge.
  - State goes to IDLE. count=0, reload register=0.
  - running=0, done=0, expired=0.
- States: IDLE, RUN, PAUSED, DONE.
- Outputs
  - All outputs are registered.
  - running=(state==RUN); done=(state==DONE).
- Sanitize rule
  - Any load_value digit >9 is replaced by 9 before it is stored.
- Load
  - load=1 at an edge, in any state: count and reload register take the sanitized value. State goes to IDLE; expired=0.
  - load has priority over start, pause and tick in the same cycle.
- IDLE
  - start=1 with count!=0: go to RUN.
  - start=1 with count==0: go to DONE; expired pulses.
  - tick and pause are ignored.
- RUN
  - pause=1: go to PAUSED. No decrement that cycle, even with tick=1. pause wins over start.
  - Otherwise, on tick=1, count decrements by one in BCD:
    - Digit 0 decrements.
    - A digit at 0 becomes 9 and borrows into the next digit.
    - Borrow ripples combinationally through all digits in one cycle.
  - Decrement from value 1 (all upper digits 0, digit 0 = 1): count becomes 0 and the state goes to DONE on the same edge.
  - count never wraps below 0.
- PAUSED
  - count holds; tick is ignored.
  - start=1: go to RUN. No decrement on the resuming edge.
  - pause is ignored.
- DONE
  - count holds at 0; tick and pause are ignored.
  - start=1 with reload!=0: count = reload and go to RUN (restart).
  - start=1 with reload==0: stay in DONE; expired pulses again.
- expired timing
  - expired is high exactly one cycle, the first cycle after any edge that enters DONE (or re-enters it as above).
- Latency
  - count updates one edge after a qualifying tick or load.
  - running and done follow state with no extra delay.

Test Plan:
(All DIGITS=2.)
- Reset mid-operation: load 0x25, start, 3 ticks -> count=0x22, running=1; drive reset=0 between edges -> count=0x00, running=0, done=0 before the next edge.
- Borrow chain: load 0x10, start, tick -> 0x09; tick -> 0x08; load 0x00 then start -> done=1 and expired high for exactly one cycle.
- Terminal count: load 0x02, start, ticks -> 0x01, then 0x00 with done=1, running=0, expired=1 for one cycle; 5 further ticks -> count stays 0x00, expired stays 0.
- Sanitize and priority:
  - load 0xAF -> count=0x99.
  - load 0x30 with start=1 and tick=1 in the same cycle -> count=0x30, state IDLE.
- Pause:
  - load 0x05, start, tick -> 0x04.
  - pause=1 with tick=1 -> holds 0x04, running=0.
  - 3 ticks -> 0x04.
  - start -> running=1, count 0x04; tick -> 0x03.
- Restart from DONE: load 0x03, run to 0x00 (done=1); start -> count=0x03, running=1; 3 ticks -> 0x00, expired pulses once.
